banco_ula_exec: RTL and testbench

//  Execute stage directly downstream of the control FSM. Holds the 32-entry integer register file,

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/banco_ula_exec_ula.sv | 57 +++++
 rtl/banco_ula_exec.sv | 116 +++++++++++
 tb/tb_banco_ula_exec.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the execute stage and the control FSM that drives it:
// datapath sizing, the ALU operation codes and the registered flag bundle.
package riscv_pkg;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOT  = 3'b101,
    OP_INC  = 3'b110,
    OP_CMP  = 3'b111
  } op_ula_t;

  typedef struct packed {
    logic zero;
    logic negativo;
    logic overflow;
    logic igual;
    logic maior;
    logic menor;
  } flags_t;

  // Signed overflow of a sum: operands share a sign that the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a difference: operand signs differ and result sign leaves A's.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/banco_ula_exec_ula.sv
// Purely combinational ALU: result plus zero/sign/overflow and signed A-vs-B compare flags.
module ula
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  op_ula_t         i_op,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_negativo,
  output logic            o_overflow,
  output logic            o_igual,
  output logic            o_maior,
  output logic            o_menor
);

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_inc;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_inc  = i_a + {{(XLEN-1){1'b0}}, 1'b1};

  // Operation select and overflow, which only the arithmetic ops can raise.
  always_comb begin
    o_result   = {XLEN{1'b0}};
    o_overflow = 1'b0;
    case (i_op)
      OP_PASS: o_result = i_a;
      OP_ADD: begin
        o_result   = w_sum;
        o_overflow = add_ovf(i_a[XLEN-1], i_b[XLEN-1], w_sum[XLEN-1]);
      end
      OP_SUB: begin
        o_result   = w_diff;
        o_overflow = sub_ovf(i_a[XLEN-1], i_b[XLEN-1], w_diff[XLEN-1]);
      end
      OP_AND:  o_result = i_a & i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOT:  o_result = ~i_a;
      OP_INC: begin
        o_result   = w_inc;
        o_overflow = add_ovf(i_a[XLEN-1], 1'b0, w_inc[XLEN-1]);
      end
      OP_CMP:  o_result = {XLEN{1'b0}};
      default: o_result = {XLEN{1'b0}};
    endcase
  end

  assign o_zero     = (o_result == {XLEN{1'b0}});
  assign o_negativo = o_result[XLEN-1];
  assign o_igual    = (i_a == i_b);
  assign o_maior    = ($signed(i_a) > $signed(i_b));
  assign o_menor    = ($signed(i_a) < $signed(i_b));

endmodule

// File: rtl/banco_ula_exec.sv
// Execute stage: integer register file, operand registers A/B, ALU and registered result/flags.
// Sequencing (load operands, then operate and write back) comes from the external control FSM.
module banco_ula_exec
  import riscv_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              reset_wire,
  input  logic [2:0]        operacao,
  input  logic              writeReg,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   A_out,
  output logic [XLEN-1:0]   B_out,
  output logic [XLEN-1:0]   alu_out,
  output logic              zero,
  output logic              negativo,
  output logic              overflow,
  output logic              igual,
  output logic              maior,
  output logic              menor
);

  logic [XLEN-1:0] r_rf [NREGS];
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_alu;
  flags_t          r_flags;

  op_ula_t         w_op;
  logic [XLEN-1:0] w_result;
  flags_t          w_flags;
  logic            w_we;
  logic [XLEN-1:0] w_a_next;
  logic [XLEN-1:0] w_b_next;

  assign w_op = op_ula_t'(operacao);

  ula u_ula (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_op       (w_op),
    .o_result   (w_result),
    .o_zero     (w_flags.zero),
    .o_negativo (w_flags.negativo),
    .o_overflow (w_flags.overflow),
    .o_igual    (w_flags.igual),
    .o_maior    (w_flags.maior),
    .o_menor    (w_flags.menor)
  );

  // A write is effective only outside a soft clear and never into x0; reads bypass the
  // write so an operand addressed by rd sees the value being written this edge.
  always_comb begin
    w_we     = 1'b0;
    w_a_next = {XLEN{1'b0}};
    w_b_next = {XLEN{1'b0}};
    if (writeReg && !reset_wire && (rd != {REG_AW{1'b0}})) begin
      w_we = 1'b1;
    end else begin
      w_we = 1'b0;
    end
    if (w_we && (rd == rs1)) begin
      w_a_next = w_result;
    end else if (rs1 == {REG_AW{1'b0}}) begin
      w_a_next = {XLEN{1'b0}};
    end else begin
      w_a_next = r_rf[rs1];
    end
    if (w_we && (rd == rs2)) begin
      w_b_next = w_result;
    end else if (rs2 == {REG_AW{1'b0}}) begin
      w_b_next = {XLEN{1'b0}};
    end else begin
      w_b_next = r_rf[rs2];
    end
  end

  // Register file storage; only RST clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= {XLEN{1'b0}};
      end
    end else if (w_we) begin
      r_rf[rd] <= w_result;
    end
  end

  // Operand, result and flag registers; cleared by either reset.
  always_ff @(posedge CLK) begin
    if (RST || reset_wire) begin
      r_a     <= {XLEN{1'b0}};
      r_b     <= {XLEN{1'b0}};
      r_alu   <= {XLEN{1'b0}};
      r_flags <= '0;
    end else begin
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_alu   <= w_result;
      r_flags <= w_flags;
    end
  end

  assign A_out    = r_a;
  assign B_out    = r_b;
  assign alu_out  = r_alu;
  assign zero     = r_flags.zero;
  assign negativo = r_flags.negativo;
  assign overflow = r_flags.overflow;
  assign igual    = r_flags.igual;
  assign maior    = r_flags.maior;
  assign menor    = r_flags.menor;

endmodule

// File: tb/tb_banco_ula_exec.sv
// Scoreboard bench for banco_ula_exec: a driver issues directed and random cycles and pushes
// the reference model's expected outputs; a monitor pops one entry per cycle and compares.
module tb_banco_ula_exec;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        reset_wire = 1'b0;
  logic [2:0]  operacao = 3'd0;
  logic        writeReg = 1'b0;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic [63:0] A_out, B_out, alu_out;
  logic        zero, negativo, overflow, igual, maior, menor;

  banco_ula_exec dut (
    .CLK(CLK), .RST(RST), .reset_wire(reset_wire), .operacao(operacao),
    .writeReg(writeReg), .rs1(rs1), .rs2(rs2), .rd(rd),
    .A_out(A_out), .B_out(B_out), .alu_out(alu_out),
    .zero(zero), .negativo(negativo), .overflow(overflow),
    .igual(igual), .maior(maior), .menor(menor)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] a, b, alu;
    logic        z, n, o, ig, ma, me;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] m_rf [32];
  logic [63:0] m_a = 64'd0, m_b = 64'd0;

  // Reference ALU: overflow means the exact signed result differs from the wrapped one.
  task automatic alu_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] r, output logic ovf);
    logic signed [64:0] s;
    ovf = 1'b0;
    s   = 65'sd0;
    case (op)
      3'd0: r = a;
      3'd1: begin s = $signed({a[63], a}) + $signed({b[63], b}); r = s[63:0]; ovf = (s != $signed({r[63], r})); end
      3'd2: begin s = $signed({a[63], a}) - $signed({b[63], b}); r = s[63:0]; ovf = (s != $signed({r[63], r})); end
      3'd3: r = a & b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin s = $signed({a[63], a}) + 65'sd1; r = s[63:0]; ovf = (s != $signed({r[63], r})); end
      default: r = 64'd0;
    endcase
  endtask

  task automatic step(input logic rst_i, input logic rw_i, input logic [2:0] op, input logic we,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    exp_t        e;
    logic [63:0] res;
    logic        ovf;
    @(negedge CLK);
    RST = rst_i; reset_wire = rw_i; operacao = op; writeReg = we;
    rs1 = s1; rs2 = s2; rd = d;
    e = '0;
    if (rst_i) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
      m_a = 64'd0; m_b = 64'd0;
    end else if (rw_i) begin
      m_a = 64'd0; m_b = 64'd0;
    end else begin
      alu_model(op, m_a, m_b, res, ovf);
      e.alu = res; e.z = (res == 64'd0); e.n = res[63]; e.o = ovf;
      e.ig = (m_a == m_b); e.ma = ($signed(m_a) > $signed(m_b)); e.me = ($signed(m_a) < $signed(m_b));
      if (we && d != 5'd0) m_rf[d] = res;
      m_a = (s1 == 5'd0) ? 64'd0 : m_rf[s1];
      m_b = (s2 == 5'd0) ? 64'd0 : m_rf[s2];
      e.a = m_a; e.b = m_b;
    end
    @(posedge CLK);
    sb.push_back(e);
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    step(1'b0, 1'b0, 3'd0, 1'b0, s1, s2, 5'd0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: outputs are registered, so each cycle's expected entry is checked mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("A_out", A_out, e.a);
      chk("B_out", B_out, e.b);
      chk("alu_out", alu_out, e.alu);
      chk("zero", {63'd0, zero}, {63'd0, e.z});
      chk("negativo", {63'd0, negativo}, {63'd0, e.n});
      chk("overflow", {63'd0, overflow}, {63'd0, e.o});
      chk("igual", {63'd0, igual}, {63'd0, e.ig});
      chk("maior", {63'd0, maior}, {63'd0, e.ma});
      chk("menor", {63'd0, menor}, {63'd0, e.me});
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    // Reset, then read back the whole register file through both ports.
    step(1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
    // x1 = 5 and x2 = 7 via repeated increments with write-through into A.
    idle(5'd1, 5'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd6, 1'b1, 5'd1, 5'd0, 5'd1);
    idle(5'd2, 5'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 3'd6, 1'b1, 5'd2, 5'd0, 5'd2);
    idle(5'd1, 5'd2);
    step(1'b0, 1'b0, 3'd1, 1'b1, 5'd1, 5'd2, 5'd3);
    idle(5'd3, 5'd0);
    idle(5'd0, 5'd0);
    // x6 = 1; x4 = 1 doubled 63 times to 2^63; x5 = ~x4 = max positive; then x5 + 1.
    idle(5'd6, 5'd6);
    step(1'b0, 1'b0, 3'd6, 1'b1, 5'd6, 5'd6, 5'd6);
    idle(5'd4, 5'd4);
    step(1'b0, 1'b0, 3'd6, 1'b1, 5'd4, 5'd4, 5'd4);
    for (int i = 0; i < 63; i++) step(1'b0, 1'b0, 3'd1, 1'b1, 5'd4, 5'd4, 5'd4);
    step(1'b0, 1'b0, 3'd5, 1'b1, 5'd5, 5'd6, 5'd5);
    step(1'b0, 1'b0, 3'd1, 1'b0, 5'd5, 5'd6, 5'd0);
    idle(5'd0, 5'd0);
    // Writes to x0 are dropped; rd == rs1 write-through.
    step(1'b0, 1'b0, 3'd6, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd4);
    step(1'b0, 1'b0, 3'd6, 1'b1, 5'd4, 5'd4, 5'd4);
    // A = -3, B = 2 compare with no write.
    idle(5'd6, 5'd6);
    step(1'b0, 1'b0, 3'd1, 1'b1, 5'd8, 5'd8, 5'd8);
    step(1'b0, 1'b0, 3'd5, 1'b1, 5'd9, 5'd8, 5'd9);
    step(1'b0, 1'b0, 3'd7, 1'b0, 5'd9, 5'd8, 5'd9);
    idle(5'd9, 5'd8);
    // Soft clear suppresses a simultaneous write; RST mid-sequence clears everything.
    step(1'b0, 1'b1, 3'd1, 1'b1, 5'd5, 5'd5, 5'd5);
    idle(5'd5, 5'd5);
    idle(5'd5, 5'd5);
    step(1'b1, 1'b0, 3'd1, 1'b1, 5'd5, 5'd3, 5'd5);
    idle(5'd5, 5'd3);
    idle(5'd0, 5'd0);
    // Random traffic seeded by constant-producing ops.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
    @(posedge CLK);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
